// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit.
// Moore-style sequencer: mux selects and static enables are registered from the
// next state, so they are glitch-free at the start of every state. The two
// enables that depend on inputs sampled in the current state (instruction
// fetch completion, branch outcome) are combined with the registered state.
module mc_control_fsm #(
  parameter int CNT_W           = 32,
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic [1:0]       sel_alu_src_a,
  output logic [1:0]       sel_alu_src_b,
  output logic [1:0]       sel_result,
  output logic             sel_mem_addr,
  output logic             we_pc,
  output logic             we_ir,
  output logic             we_rf,
  output logic             we_mem,
  output logic             mem_req,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADDR,
    S_JALR, S_LUI, S_AUIPC, S_HALT
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result;
    logic       mem_addr;
    logic       we_rf;
    logic       we_mem;
    logic       mem_req;
    logic       pc_update;
    logic       halted;
  } ctrl_t;

  // Per-state control word; anything not mentioned stays 0.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_req = 1'b1; c.src_b = 2'b10; c.result = 2'b10; end
      S_DECODE:    begin c.src_a = 2'b01; c.src_b = 2'b01; end
      S_MEMADR:    begin c.src_a = 2'b10; c.src_b = 2'b01; end
      S_MEMREAD:   begin c.mem_req = 1'b1; c.mem_addr = 1'b1; end
      S_MEMWB:     begin c.result = 2'b01; c.we_rf = 1'b1; end
      S_MEMWRITE:  begin c.mem_req = 1'b1; c.we_mem = 1'b1; c.mem_addr = 1'b1; end
      S_EXECUTER:  begin c.src_a = 2'b10; c.src_b = 2'b00; c.alu_op = 2'b10; end
      S_EXECUTEI:  begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:     begin c.we_rf = 1'b1; end
      S_BRANCH:    begin c.src_a = 2'b10; c.src_b = 2'b00; c.alu_op = 2'b01; end
      S_JAL:       begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_update = 1'b1; end
      S_JALR_ADDR: begin c.src_a = 2'b10; c.src_b = 2'b01; end
      S_JALR:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_update = 1'b1; end
      S_LUI:       begin c.src_a = 2'b11; c.src_b = 2'b01; end
      S_AUIPC:     begin c.src_a = 2'b01; c.src_b = 2'b01; end
      S_HALT:      begin c.halted = 1'b1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  state_t           state_reg, state_next;
  ctrl_t            ctrl_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] retire_reg;
  logic             mem_ready_eff;
  logic             illegal_det;
  logic             retire_inc;
  logic             branch_taken;

  assign mem_ready_eff = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Branch condition from funct3; the two reserved encodings never reach BRANCH.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = ~lt;
      3'b110:  branch_taken = ltu;
      3'b111:  branch_taken = ~ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state selection, illegal-opcode detection and retire strobe.
  always_comb begin
    state_next  = state_reg;
    illegal_det = 1'b0;
    case (state_reg)
      S_FETCH:    if (mem_ready_eff) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_BRANCH: begin
            if (funct3 == 3'b010 || funct3 == 3'b011) illegal_det = 1'b1;
            else                                      state_next  = S_BRANCH;
          end
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR_ADDR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          OP_SYSTEM:         state_next = S_HALT;
          default:           illegal_det = 1'b1;
        endcase
        if (illegal_det) state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      end
      S_MEMADR:    state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:   if (mem_ready_eff) state_next = S_MEMWB;
      S_MEMWB:     state_next = S_FETCH;
      S_MEMWRITE:  if (mem_ready_eff) state_next = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI,
      S_LUI,
      S_AUIPC,
      S_JAL,
      S_JALR:      state_next = S_ALUWB;
      S_JALR_ADDR: state_next = S_JALR;
      S_ALUWB:     state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_FETCH;
    endcase
    retire_inc = (state_next == S_FETCH) &&
                 (state_reg inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});
  end

  // State, registered control word, sticky illegal flag and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      ctrl_reg    <= ctrl_of(S_FETCH);
      illegal_reg <= 1'b0;
      retire_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_of(state_next);
      if (illegal_det) illegal_reg <= 1'b1;
      if (retire_inc)  retire_reg  <= retire_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign alu_op        = ctrl_reg.alu_op;
  assign sel_alu_src_a = ctrl_reg.src_a;
  assign sel_alu_src_b = ctrl_reg.src_b;
  assign sel_result    = ctrl_reg.result;
  assign sel_mem_addr  = ctrl_reg.mem_addr;

  // Enables are suppressed for as long as reset is held.
  assign we_ir   = ~reset & (state_reg == S_FETCH) & mem_ready_eff;
  assign we_pc   = ~reset & (((state_reg == S_BRANCH) & branch_taken) |
                             ctrl_reg.pc_update |
                             ((state_reg == S_FETCH) & mem_ready_eff));
  assign we_rf   = ~reset & ctrl_reg.we_rf;
  assign we_mem  = ~reset & ctrl_reg.we_mem;
  assign mem_req = ~reset & ctrl_reg.mem_req;

  assign illegal      = illegal_reg;
  assign halted       = ctrl_reg.halted;
  assign retire_count = retire_reg;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter: CNT_W, default 32, width of retire counter.
REQ-002 Parameter: MEM_HANDSHAKE, default 1; 0 = mem_ready ignored, treated as constant 1.
REQ-003 Parameter: HALT_ON_ILLEGAL, default 1; 1 = illegal instruction enters HALT, 0 = illegal instruction treated as NOP.
REQ-004 Ports: clk input 1 clock; reset input 1 synchronous, active-high reset.
REQ-005 Inputs: op 7 opcode; funct3 3 instr[14:12]; zero 1 ALU zero; lt 1 signed less-than; ltu 1 unsigned less-than; mem_ready 1 memory access complete this cycle.
REQ-006 Outputs, control: alu_op 2; sel_alu_src_a 2 (00 PC, 01 oldPC, 10 rs1, 11 zero); sel_alu_src_b 2 (00 rs2, 01 imm, 10 const 4); sel_result 2 (00 ALUOut, 01 mem data, 10 ALU result); sel_mem_addr 1 (0 PC, 1 result).
REQ-007 Outputs, enables: we_pc, we_ir, we_rf, we_mem, mem_req, each 1 bit.
REQ-008 Outputs, status: illegal 1 sticky; halted 1; retire_count CNT_W instructions completed.

Function
REQ-009 Moore FSM; states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR_ADDR, JALR, LUI, AUIPC, HALT; unlisted outputs default 0.
REQ-010 we_pc = (branch_taken AND state==BRANCH) OR pc_update.
REQ-011 FETCH: mem_req=1, sel_mem_addr=0, src_a=00, src_b=10, alu_op=00, sel_result=10; we_ir=pc_update=mem_ready; go to DECODE only when mem_ready=1, else hold FETCH.
REQ-012 DECODE: src_a=01, src_b=01, alu_op=00; next by op: 0000011/0100011 MEMADR, 0110011 EXECUTER, 0010011 EXECUTEI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR_ADDR, 0110111 LUI, 0010111 AUIPC, 1110011 HALT (illegal stays 0).
REQ-013 DECODE illegal: any other op, or op=1100011 with funct3 010/011; sets illegal=1; next HALT if HALT_ON_ILLEGAL=1, else FETCH.
REQ-014 MEMADR: src_a=10, src_b=01, alu_op=00; next MEMREAD (load) or MEMWRITE (store).
REQ-015 MEMREAD: mem_req=1, sel_mem_addr=1, sel_result=00; hold until mem_ready=1, then MEMWB.
REQ-016 MEMWB: sel_result=01, we_rf=1; next FETCH.
REQ-017 MEMWRITE: mem_req=1, we_mem=1, sel_mem_addr=1, sel_result=00; hold (we_mem stable) until mem_ready=1, then FETCH.
REQ-018 EXECUTER: src_a=10, src_b=00, alu_op=10. EXECUTEI: src_a=10, src_b=01, alu_op=10. Both next ALUWB.
REQ-019 LUI: src_a=11, src_b=01, alu_op=00. AUIPC: src_a=01, src_b=01, alu_op=00. Both next ALUWB.
REQ-020 JAL: src_a=01, src_b=10, alu_op=00, sel_result=00, pc_update=1; next ALUWB.
REQ-021 JALR_ADDR: src_a=10, src_b=01, alu_op=00; next JALR. JALR: identical outputs to JAL; next ALUWB.
REQ-022 ALUWB: sel_result=00, we_rf=1; next FETCH.
REQ-023 BRANCH: src_a=10, src_b=00, alu_op=01; branch_taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; next FETCH.
REQ-024 HALT: all enables 0, halted=1; leaves only on reset.
REQ-025 retire_count increments by 1, modulo 2^CNT_W, on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH; illegal-as-NOP and HALT entry do not increment.
REQ-026 Wait states: all outputs held constant while waiting on mem_ready.

Reset
REQ-027 reset=1 at a clock edge: state<=FETCH, retire_count<=0, illegal<=0; takes priority over every transition, including mid-wait and HALT.
REQ-028 While reset=1: we_pc, we_ir, we_rf, we_mem, mem_req forced 0.

Verification
REQ-029 R-type (op=0110011), mem_ready=1 -> states FETCH,DECODE,EXECUTER,ALUWB,FETCH; we_rf=1 one cycle; retire_count 0->1.
REQ-030 Load with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, outputs constant, MEMWB we_rf=1; retire_count +1.
REQ-031 BNE (funct3=001): zero=0 -> we_pc=1 in BRANCH; zero=1 -> we_pc=0; BGEU with ltu=0 -> we_pc=1.
REQ-032 JALR -> FETCH,DECODE,JALR_ADDR,JALR(we_pc=1, src_a=01, src_b=10),ALUWB(we_rf=1).
REQ-033 op=1111111 with HALT_ON_ILLEGAL=1 -> illegal=1, halted=1, enables 0 for 10 cycles; reset -> FETCH, illegal=0, retire_count=0. With HALT_ON_ILLEGAL=0 -> FETCH, retire_count unchanged.
REQ-034 CNT_W=4, 16 retired instructions -> retire_count wraps 15->0.
